load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access load/store bus master with timeout and sub-word lanes.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses without touching the bus.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  MemRead,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [CW-1:0] cnt_next;
  logic          timeout;
  logic          req_ok;
  logic          trap;
  logic          lat_load;
  logic [2:0]    lat_kind;
  logic [1:0]    lat_off;
  logic [3:0]    st_be;
  logic [31:0]   st_wd;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld_val;

  assign req_ok   = start && (load || (MemWrite != 2'b00));
  assign cnt_next = counter + 1'b1;
  assign timeout  = (cnt_next == CW'(TIMEOUT_CYC));

`ifdef LSU_MISALIGN_TRAP_EN
  logic is_half;
  logic is_word;
  assign is_half = load ? ((MemRead == 3'b010) || (MemRead == 3'b100)) : (MemWrite == 2'b10);
  assign is_word = load ? !((MemRead == 3'b001) || (MemRead == 3'b010) ||
                            (MemRead == 3'b011) || (MemRead == 3'b100))
                        : (MemWrite == 2'b11);
  assign trap    = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    st_be = 4'b1111;
    st_wd = wdata;
    case (MemWrite)
      2'b01: begin
        st_be = 4'b0001 << addr[1:0];
        st_wd = {4{wdata[7:0]}};
      end
      2'b10: begin
        st_be = addr[1] ? 4'b1100 : 4'b0011;
        st_wd = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at start, not the live addr input.
  assign lane_b = bus_rdata[{lat_off, 3'b000} +: 8];
  assign lane_h = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    ld_val = bus_rdata;
    case (lat_kind)
      3'b001:  ld_val = {{24{lane_b[7]}}, lane_b};
      3'b010:  ld_val = {{16{lane_h[15]}}, lane_h};
      3'b011:  ld_val = {24'h0, lane_b};
      3'b100:  ld_val = {16'h0, lane_h};
      default: ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'h0;
      err        <= 1'b0;
      misaligned <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wdata  <= 32'h0;
      lat_load   <= 1'b0;
      lat_kind   <= 3'b000;
      lat_off    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req_ok) begin
            lat_load  <= load;
            lat_kind  <= MemRead;
            lat_off   <= addr[1:0];
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= !load;
            bus_be    <= load ? 4'b1111 : st_be;
            bus_wdata <= load ? 32'h0 : st_wd;
            busy      <= 1'b1;
            counter   <= '0;
            if (trap) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
              err        <= 1'b0;
              rdata      <= 32'h0;
            end else begin
              state   <= REQ;
              bus_req <= 1'b1;
            end
          end
        end
        REQ: begin
          counter <= cnt_next;
          if (bus_gnt) begin
            bus_req <= 1'b0;
            if (lat_load) begin
              state <= WAIT;
            end else begin
              state      <= DONE;
              done       <= 1'b1;
              rdata      <= 32'h0;
              err        <= 1'b0;
              misaligned <= 1'b0;
            end
          end else if (timeout) begin
            bus_req    <= 1'b0;
            state      <= DONE;
            done       <= 1'b1;
            rdata      <= 32'h0;
            err        <= 1'b1;
            misaligned <= 1'b0;
          end
        end
        WAIT: begin
          counter <= cnt_next;
          // Data arriving on the final allowed cycle still completes normally.
          if (bus_rvalid) begin
            state      <= DONE;
            done       <= 1'b1;
            rdata      <= ld_val;
            err        <= 1'b0;
            misaligned <= 1'b0;
          end else if (timeout) begin
            state      <= DONE;
            done       <= 1'b1;
            rdata      <= 32'h0;
            err        <= 1'b1;
            misaligned <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  MemWrite = 2'b00;
  logic [2:0]  MemRead = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, misaligned, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  typedef struct {
    logic        ld;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          lat;
    bit          req;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        m_e;
  int          total = 0;
  int          bad = 0;
  int          cyc_count = 0;
  int          start_cyc = 0;
  bit          req_seen = 0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wd = 32'h0;
  logic [3:0]  m_be = 4'h0;
  logic        m_we = 1'b0;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load), .MemWrite(MemWrite),
    .MemRead(MemRead), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .misaligned(misaligned), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  always @(negedge clk) begin
    if (rst_n && bus_req) begin
      req_seen = 1;
      m_addr = bus_addr;
      m_be = bus_be;
      m_wd = bus_wdata;
      m_we = bus_we;
    end
    if (rst_n && done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1 want no completion");
      end else begin
        m_e = exp_q.pop_front();
        if (m_e.ld) begin
          total++;
          if (rdata !== m_e.rdata) begin bad++; $display("FAIL rdata: got %h want %h", rdata, m_e.rdata); end
        end
        total++;
        if (err !== m_e.err) begin bad++; $display("FAIL err: got %b want %b", err, m_e.err); end
        total++;
        if (misaligned !== m_e.mis) begin bad++; $display("FAIL misaligned: got %b want %b", misaligned, m_e.mis); end
        total++;
        if (cyc_count - start_cyc != m_e.lat) begin
          bad++; $display("FAIL latency: got %0d want %0d", cyc_count - start_cyc, m_e.lat);
        end
        total++;
        if (req_seen != m_e.req) begin bad++; $display("FAIL bus_req_seen: got %0d want %0d", req_seen, m_e.req); end
        if (m_e.req && req_seen) begin
          total++;
          if (m_addr !== m_e.baddr) begin bad++; $display("FAIL bus_addr: got %h want %h", m_addr, m_e.baddr); end
          total++;
          if (m_be !== m_e.be) begin bad++; $display("FAIL bus_be: got %b want %b", m_be, m_e.be); end
          total++;
          if (m_we !== m_e.we) begin bad++; $display("FAIL bus_we: got %b want %b", m_we, m_e.we); end
          if (m_e.we) begin
            total++;
            if (m_wd !== m_e.bwd) begin bad++; $display("FAIL bus_wdata: got %h want %h", m_wd, m_e.bwd); end
          end
        end
      end
    end
  end

  function automatic exp_t mk(input logic ld, input logic [31:0] rd, input logic e, input logic mis,
                              input int lat, input bit req, input logic [31:0] ba, input logic [3:0] be,
                              input logic [31:0] bwd);
    exp_t x;
    x.ld = ld; x.rdata = rd; x.err = e; x.mis = mis; x.lat = lat; x.req = req;
    x.baddr = ba; x.be = be; x.bwd = bwd; x.we = !ld;
    return x;
  endfunction

  // Drives one access and plays the bus slave; gnt_wait < 0 never grants.
  task automatic drive(input logic ld, input logic [1:0] mw, input logic [2:0] mr,
                       input logic [31:0] a, input logic [31:0] wd, input int gnt_wait,
                       input int rv_wait, input logic [31:0] brd, input bit stray,
                       input bit poke, output int busy_drops);
    int gcnt = 0;
    int gcyc = 0;
    bit given = 0;
    busy_drops = 0;
    @(negedge clk);
    load = ld; MemWrite = mw; MemRead = mr; addr = a; wdata = wd; start = 1'b1;
    start_cyc = cyc_count;
    req_seen = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = poke && (c == 1);
      if (poke && c == 1) addr = 32'hFFFF_FFF0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      if (done) return;
      if (!busy) busy_drops++;
      if (bus_req) begin
        if (stray) begin bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF; end
        if (gnt_wait >= 0 && gcnt == gnt_wait) begin bus_gnt = 1'b1; given = 1; gcyc = c; end
        gcnt++;
      end else if (given && c == gcyc + rv_wait) begin
        bus_rvalid = 1'b1; bus_rdata = brd;
      end
    end
    total++; bad++;
    $display("FAIL drive_timeout: got no done within 100 cycles want done");
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, done, err, misaligned, bus_req, bus_we} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {busy, done, err, misaligned, bus_req, bus_we});
    end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    total++;
    if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    total++;
    if (bus_be !== 4'h0) begin bad++; $display("FAIL reset_bus_be: got %b want 0000", bus_be); end
    total++;
    if (bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    int bd;
    exp_q.push_back(mk(0, 0, 0, 0, 2, 1, 32'h100, 4'b1000, 32'hABABABAB));
    drive(0, 2'b01, 3'b000, 32'h103, 32'hAB, 0, 0, 0, 0, 0, bd);
    exp_q.push_back(mk(0, 0, 0, 0, 2, 1, 32'h100, 4'b1100, 32'h12341234));
    drive(0, 2'b10, 3'b000, 32'h102, 32'hFFFF1234, 0, 0, 0, 0, 0, bd);
    exp_q.push_back(mk(0, 0, 0, 0, 4, 1, 32'h200, 4'b0011, 32'h56785678));
    drive(0, 2'b10, 3'b000, 32'h200, 32'h00005678, 2, 0, 0, 0, 0, bd);
    exp_q.push_back(mk(0, 0, 0, 0, 2, 1, 32'h010, 4'b1111, 32'hDEADBEEF));
    drive(0, 2'b11, 3'b000, 32'h010, 32'hDEADBEEF, 0, 0, 0, 0, 0, bd);
  endtask

  task automatic test_load();
    int bd;
    exp_q.push_back(mk(1, 32'hFFFFFFF0, 0, 0, 3, 1, 32'h200, 4'b1111, 0));
    drive(1, 2'b00, 3'b001, 32'h201, 0, 0, 1, 32'h0000F000, 0, 0, bd);
    exp_q.push_back(mk(1, 32'h000000F0, 0, 0, 4, 1, 32'h200, 4'b1111, 0));
    drive(1, 2'b00, 3'b011, 32'h201, 0, 1, 1, 32'h0000F000, 1, 0, bd);
    exp_q.push_back(mk(1, 32'hFFFF8001, 0, 0, 5, 1, 32'h000, 4'b1111, 0));
    drive(1, 2'b00, 3'b010, 32'h002, 0, 0, 3, 32'h8001FFFF, 0, 0, bd);
    total++;
    if (bd != 0) begin bad++; $display("FAIL lh_busy_held: got %0d idle cycles want 0", bd); end
    exp_q.push_back(mk(1, 32'h00008001, 0, 0, 3, 1, 32'h000, 4'b1111, 0));
    drive(1, 2'b00, 3'b100, 32'h002, 0, 0, 1, 32'h8001FFFF, 0, 0, bd);
    exp_q.push_back(mk(1, 32'hCAFEF00D, 0, 0, 3, 1, 32'h040, 4'b1111, 0));
    drive(1, 2'b00, 3'b000, 32'h040, 0, 0, 1, 32'hCAFEF00D, 0, 0, bd);
    exp_q.push_back(mk(1, 32'h87654321, 0, 0, 3, 1, 32'h044, 4'b1111, 0));
    drive(1, 2'b00, 3'b101, 32'h044, 0, 0, 1, 32'h87654321, 0, 0, bd);
  endtask

  task automatic test_timeout();
    int bd;
    exp_q.push_back(mk(1, 32'h0, 1, 0, 5, 1, 32'h300, 4'b1111, 0));
    drive(1, 2'b00, 3'b000, 32'h300, 0, -1, 0, 0, 0, 0, bd);
    total++;
    if (bus_req !== 1'b0) begin bad++; $display("FAIL timeout_req_drop: got %b want 0", bus_req); end
    exp_q.push_back(mk(1, 32'h00000055, 0, 0, 3, 1, 32'h304, 4'b1111, 0));
    drive(1, 2'b00, 3'b011, 32'h304, 0, 0, 1, 32'h00000055, 0, 0, bd);
  endtask

  task automatic test_misalign();
    int bd;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
`else
    exp_q.push_back(mk(0, 0, 0, 0, 2, 1, 32'h004, 4'b1111, 32'h11223344));
`endif
    drive(0, 2'b11, 3'b000, 32'h006, 32'h11223344, 0, 0, 0, 0, 0, bd);
  endtask

  task automatic test_ignored();
    int bd;
    @(negedge clk);
    load = 1'b0; MemWrite = 2'b00; addr = 32'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (busy !== 1'b0 || bus_req !== 1'b0) begin
        bad++; $display("FAIL null_start: got busy=%b bus_req=%b want 0 0", busy, bus_req);
      end
      @(negedge clk);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 4, 1, 32'h080, 4'b1111, 32'h0BADF00D));
    drive(0, 2'b11, 3'b000, 32'h080, 32'h0BADF00D, 2, 0, 0, 0, 1, bd);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_while_busy: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int bd;
    @(negedge clk);
    load = 1'b1; MemRead = 3'b000; addr = 32'h600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (bus_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", bus_req); end
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || bus_req !== 1'b0) begin
      bad++; $display("FAIL async_reset: got busy=%b bus_req=%b want 0 0", busy, bus_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(mk(1, 32'hFFFFFF80, 0, 0, 3, 1, 32'h700, 4'b1111, 0));
    drive(1, 2'b00, 3'b001, 32'h702, 0, 0, 1, 32'h00800000, 0, 0, bd);
  endtask

  task automatic test_back_to_back();
    int bd;
    int gw;
    logic [31:0] a, wd, ewd;
    logic [1:0]  mw;
    logic [3:0]  ebe;
    for (int i = 0; i < 6; i++) begin
      a = $urandom; wd = $urandom; mw = 2'($urandom_range(1, 3)); gw = $urandom_range(0, 2);
      if (mw == 2'b10) a[0] = 1'b0;
      if (mw == 2'b11) a[1:0] = 2'b00;
      case (mw)
        2'b01:   begin ebe = 4'b0001 << a[1:0]; ewd = {4{wd[7:0]}}; end
        2'b10:   begin ebe = a[1] ? 4'b1100 : 4'b0011; ewd = {2{wd[15:0]}}; end
        default: begin ebe = 4'b1111; ewd = wd; end
      endcase
      exp_q.push_back(mk(0, 0, 0, 0, 2 + gw, 1, {a[31:2], 2'b00}, ebe, ewd));
      drive(0, mw, 3'b000, a, wd, gw, 0, 0, 0, 0, bd);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_misalign();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
